// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating mux: picks one valid input channel per beat, optionally holding the grant for a burst.
// Latency: 1 cycle from input accept to o_valid; throughput 1 beat/cycle through a one-entry output register.
// Backpressure: the output register reloads only when empty or drained by i_ready; otherwise every o_ready stays low.
module rr_arb_mux #(
    parameter int NUM_INPUTS   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_ON_LAST = 1,
    localparam int SEL_BITS    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS-1:0]            i_last,
    output logic [NUM_INPUTS-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_valid,
    output logic                             o_last,
    output logic [SEL_BITS-1:0]              o_select,
    input  logic                             i_ready
);

    localparam int IW = SEL_BITS + 1;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SEL_BITS-1:0]   rr_ptr;
    logic [SEL_BITS-1:0]   lock_ch;
    logic [SEL_BITS-1:0]   grant;
    logic [SEL_BITS-1:0]   grant_nxt;
    logic                  grant_vld;
    logic                  grant_last;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [IW-1:0]         idx;
    logic                  load_en;
    logic                  accept;
    logic                  burst_end;

    // Scan offsets from the far end back to rr_ptr so the last hit is the nearest valid channel.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        if (state_q == LOCKED) begin
            grant = lock_ch;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (lock_ch == SEL_BITS'(k)) begin
                    grant_vld = i_valid[k];
                end
            end
        end else begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                idx = IW'(rr_ptr) + IW'(i);
                if (idx >= IW'(NUM_INPUTS)) begin
                    idx = idx - IW'(NUM_INPUTS);
                end
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (idx == IW'(k) && i_valid[k]) begin
                        grant     = SEL_BITS'(k);
                        grant_vld = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (grant == SEL_BITS'(k)) begin
                grant_data = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
                grant_last = i_last[k];
            end
        end
    end

    assign load_en   = !o_valid || i_ready;
    assign accept    = load_en && grant_vld && !i_rst;
    assign burst_end = (LOCK_ON_LAST == 0) || grant_last;
    assign grant_nxt = (grant == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : grant + SEL_BITS'(1);

    always_comb begin
        o_ready = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            o_ready[k] = accept && (grant == SEL_BITS'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = burst_end ? ARB : LOCKED;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (burst_end) begin
                    rr_ptr <= grant_nxt;
                end else begin
                    lock_ch <= grant;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
            o_select <= '0;
        end else if (accept) begin
            o_valid  <= 1'b1;
            o_data   <= grant_data;
            o_last   <= grant_last;
            o_select <= grant;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
